// File: rtl/wb_config_readback.sv
// Wishbone readback of the fabric configuration chain: shifts, packs to 32-bit words, buffers in a FIFO.
// Latency: ack one cycle after a selected strobe; a word is pushed on the edge its last bit is sampled.
// Backpressure: a full word FIFO holds shift enable low; shifting resumes the cycle after a DATA pop.

module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_vld,
    input  logic [WIDTH-1:0]         wr_dat,
    input  logic                     rd_rdy,
    output logic [WIDTH-1:0]         rd_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_wr;
    logic             do_rd;

    assign full   = (level == (AW+1)'(DEPTH));
    assign empty  = (level == '0);
    assign do_wr  = wr_vld & ~full;
    assign do_rd  = rd_rdy & ~empty;
    assign rd_dat = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wptr] <= wr_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_wr) wptr <= wptr + AW'(1);
            if (do_rd) rptr <= rptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end
endmodule

module wb_config_readback #(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0100,
    parameter int          FIFO_DEPTH = 4,
    parameter int          CNT_W      = 20
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        cfg_shift_en_o,
    input  logic        cfg_sout_i,
    output logic        cfg_sin_o,
    output logic        irq_o
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] len;
    logic [CNT_W-1:0] bitcnt;
    logic [31:0]      pack;
    logic [31:0]      word_nxt;
    logic             done;
    logic             underflow;

    logic        acc, wr, rd;
    logic [1:0]  off;
    logic        ctrl_wr, start_req, abort_req, clear_req, pop_req;
    logic        last_bit, push, pop;
    logic        full, empty;
    logic [LW-1:0] level;
    logic [31:0] head;
    logic [31:0] rdata;
    logic        unused_ok;

    assign unused_ok = ^{wbs_sel_i, wbs_adr_i[1:0], wbs_dat_i};

    // One access per two cycles: a strobe is only accepted while ack is low.
    assign acc = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]) & ~wbs_ack_o;
    assign wr  = acc & wbs_we_i;
    assign rd  = acc & ~wbs_we_i;
    assign off = wbs_adr_i[3:2];

    assign ctrl_wr   = wr & (off == 2'd0);
    assign abort_req = ctrl_wr & wbs_dat_i[1];
    assign start_req = ctrl_wr & wbs_dat_i[0] & ~wbs_dat_i[1];
    assign clear_req = ctrl_wr & wbs_dat_i[2];
    assign pop_req   = rd & (off == 2'd3);

    assign cfg_shift_en_o = (state == SHIFT) & ~full;
    assign cfg_sin_o      = cfg_shift_en_o & cfg_sout_i;
    assign irq_o          = done;

    // Pack bits above bitcnt are always zero, so OR-ing in the new bit also zero-pads a short word.
    assign word_nxt = pack | (32'(cfg_sout_i) << bitcnt[4:0]);
    assign last_bit = (bitcnt == len - CNT_W'(1));
    assign push     = cfg_shift_en_o & ((bitcnt[4:0] == 5'd31) | last_bit);
    assign pop      = pop_req & ~empty;

    sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (wb_clk_i),
        .rst    (wb_rst_i),
        .wr_vld (push),
        .wr_dat (word_nxt),
        .rd_rdy (pop),
        .rd_dat (head),
        .full   (full),
        .empty  (empty),
        .level  (level)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_req) state_nxt = (len != '0) ? SHIFT : DONE;
            SHIFT: begin
                if (abort_req)                        state_nxt = IDLE;
                else if (cfg_shift_en_o && last_bit)  state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rdata = '0;
        case (off)
            2'd1:    rdata = {{(32-CNT_W){1'b0}}, len};
            2'd2:    rdata = {16'h0, 8'(level), 5'h0, underflow, done, (state != IDLE)};
            2'd3:    rdata = empty ? 32'h0 : head;
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            len       <= '0;
            bitcnt    <= '0;
            pack      <= '0;
            done      <= 1'b0;
            underflow <= 1'b0;
        end else begin
            state     <= state_nxt;
            wbs_ack_o <= acc;
            wbs_dat_o <= rd ? rdata : 32'h0;

            if (wr && off == 2'd1 && state == IDLE) begin
                len <= wbs_dat_i[CNT_W-1:0];
            end

            if (state == IDLE && start_req) begin
                bitcnt <= '0;
                pack   <= '0;
            end else if (cfg_shift_en_o) begin
                bitcnt <= bitcnt + CNT_W'(1);
                pack   <= push ? 32'h0 : word_nxt;
            end

            if ((state == IDLE && start_req) || clear_req) begin
                done <= 1'b0;
            end else if (state == DONE && !abort_req) begin
                done <= 1'b1;
            end

            if (clear_req) begin
                underflow <= 1'b0;
            end else if (pop_req && empty) begin
                underflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_wb_config_readback.sv
// Directed bench for wb_config_readback: bus reads go through a scoreboard queue checked by an ack monitor.
module tb_wb_config_readback;
    localparam logic [31:0] BASE = 32'h3000_0100;
    localparam logic [31:0] A_CTRL = 32'h0, A_LEN = 32'h4, A_STAT = 32'h8, A_DATA = 32'hC;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i, wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        cfg_shift_en_o, cfg_sout_i, cfg_sin_o, irq_o;

    always #5 wb_clk_i = ~wb_clk_i;

    wb_config_readback dut (
        .wb_clk_i       (wb_clk_i),
        .wb_rst_i       (wb_rst_i),
        .wbs_cyc_i      (wbs_cyc_i),
        .wbs_stb_i      (wbs_stb_i),
        .wbs_we_i       (wbs_we_i),
        .wbs_sel_i      (wbs_sel_i),
        .wbs_adr_i      (wbs_adr_i),
        .wbs_dat_i      (wbs_dat_i),
        .wbs_ack_o      (wbs_ack_o),
        .wbs_dat_o      (wbs_dat_o),
        .cfg_shift_en_o (cfg_shift_en_o),
        .cfg_sout_i     (cfg_sout_i),
        .cfg_sin_o      (cfg_sin_o),
        .irq_o          (irq_o)
    );

    // Chain model: tail at chain[chain_len-1], head input at bit 0.
    logic [255:0] chain;
    logic [255:0] load_val;
    logic         load;
    int           chain_len = 8;
    int           shift_cnt = 0;

    assign cfg_sout_i = chain[chain_len-1];

    always @(posedge wb_clk_i) begin
        if (load) begin
            chain <= load_val;
        end else if (cfg_shift_en_o) begin
            chain     <= {chain[254:0], cfg_sin_o};
            shift_cnt <= shift_cnt + 1;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] exp;
        string       name;
    } exp_t;
    exp_t sbq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge wb_clk_i);
            #1;
            if (wbs_ack_o && !wbs_we_i) begin
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_ack: got data %h, expected no read ack", wbs_dat_o);
                end else begin
                    e = sbq.pop_front();
                    check(e.name, wbs_dat_o, e.exp);
                end
            end
        end
    end

    task automatic wb_cycle(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [31:0] exp, input string name);
        int cyc_n;
        @(negedge wb_clk_i);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = w;
        wbs_adr_i = BASE + a;
        wbs_dat_i = d;
        if (!w) sbq.push_back('{exp: exp, name: name});
        cyc_n = 0;
        do begin
            @(negedge wb_clk_i);
            cyc_n++;
        end while (!wbs_ack_o && cyc_n < 8);
        check({name, "_ack_latency"}, 32'(cyc_n), 32'd1);
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        wbs_dat_i = '0;
    endtask

    task automatic wb_wr(input logic [31:0] a, input logic [31:0] d, input string name);
        wb_cycle(1'b1, a, d, 32'h0, name);
    endtask

    task automatic wb_rd(input logic [31:0] a, input logic [31:0] exp, input string name);
        wb_cycle(1'b0, a, 32'h0, exp, name);
    endtask

    function automatic logic pat(input int psel, input int i);
        if (psel == 0) return i[0];
        return ((((i * 13) >> 2) ^ (i >> 4)) & 1) != 0;
    endfunction

    function automatic logic [31:0] exp_word(input int psel, input int len, input int k);
        logic [31:0] w;
        w = '0;
        for (int j = 0; j < 32; j++) begin
            if (32 * k + j < len) w[j] = pat(psel, 32 * k + j);
        end
        return w;
    endfunction

    task automatic preload(input int len, input int psel);
        @(negedge wb_clk_i);
        load_val = '0;
        for (int i = 0; i < len; i++) load_val[len-1-i] = pat(psel, i);
        chain_len = len;
        load = 1'b1;
        @(negedge wb_clk_i);
        load = 1'b0;
    endtask

    function automatic logic chain_intact(input int len);
        logic [255:0] mask;
        mask = (256'b1 << len) - 256'b1;
        return (chain & mask) == (load_val & mask);
    endfunction

    task automatic wait_shifts(input int base, input int target, input string name);
        int c;
        c = 0;
        while ((shift_cnt - base) < target && c < 600) begin
            @(negedge wb_clk_i);
            c++;
        end
        check({name, "_reached"}, 32'(c < 600), 32'd1);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_ack"},      32'(wbs_ack_o),      32'd0);
        check({name, "_dat"},      wbs_dat_o,           32'd0);
        check({name, "_shift_en"}, 32'(cfg_shift_en_o), 32'd0);
        check({name, "_sin"},      32'(cfg_sin_o),      32'd0);
        check({name, "_irq"},      32'(irq_o),          32'd0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin : stim
        int base;
        int c;
        int n;
        wb_rst_i  = 1'b1;
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        wbs_sel_i = 4'hF;
        wbs_adr_i = '0;
        wbs_dat_i = '0;
        load      = 1'b0;
        load_val  = '0;
        repeat (3) @(negedge wb_clk_i);
        check_reset_outputs("reset");
        wb_rst_i = 1'b0;
        wb_rd(A_CTRL, 32'h0, "ctrl_reads_zero");
        wb_rd(A_LEN,  32'h0, "len_reset");
        wb_rd(A_STAT, 32'h0, "status_reset");

        // Underflow
        wb_rd(A_DATA, 32'h0, "pop_empty");
        wb_rd(A_STAT, 32'h4, "status_underflow");
        wb_wr(A_CTRL, 32'h4, "clear");
        wb_rd(A_STAT, 32'h0, "status_uf_cleared");

        // 40-bit readback
        preload(40, 0);
        base = shift_cnt;
        wb_wr(A_LEN, 32'd40, "len40");
        wb_wr(A_CTRL, 32'h1, "start40");
        c = 0;
        while (!irq_o && c < 300) begin
            @(negedge wb_clk_i);
            c++;
        end
        check("t40_irq", 32'(irq_o), 32'd1);
        check("t40_shift_cycles", 32'(shift_cnt - base), 32'd40);
        check("t40_chain_restored", 32'(chain_intact(40)), 32'd1);
        wb_rd(A_STAT, 32'h0000_0202, "t40_status");
        wb_rd(A_DATA, 32'hAAAA_AAAA, "t40_word0");
        wb_rd(A_DATA, 32'h0000_00AA, "t40_word1");
        wb_rd(A_STAT, 32'h0000_0002, "t40_status_drained");
        wb_wr(A_CTRL, 32'h4, "clear");
        check("t40_irq_cleared", 32'(irq_o), 32'd0);

        // LEN = 0
        base = shift_cnt;
        wb_wr(A_LEN, 32'd0, "len0");
        wb_wr(A_CTRL, 32'h1, "start0");
        @(negedge wb_clk_i);
        check("len0_done_irq", 32'(irq_o), 32'd1);
        check("len0_shifts", 32'(shift_cnt - base), 32'd0);
        wb_rd(A_STAT, 32'h2, "len0_status");

        // Backpressure, LEN = 200
        preload(200, 1);
        base = shift_cnt;
        wb_wr(A_LEN, 32'd200, "len200");
        wb_wr(A_CTRL, 32'h1, "start200");
        wait_shifts(base, 128, "bp_fill");
        repeat (6) @(negedge wb_clk_i);
        check("bp_stall_shifts", 32'(shift_cnt - base), 32'd128);
        check("bp_stall_shift_en", 32'(cfg_shift_en_o), 32'd0);
        wb_rd(A_STAT, 32'h0000_0401, "bp_status_full");
        for (int k = 0; k < 7; k++) begin
            wb_rd(A_DATA, exp_word(1, 200, k), $sformatf("bp_word%0d", k));
            repeat (40) @(negedge wb_clk_i);
            n = 128 + 32 * (k + 1);
            if (n > 200) n = 200;
            check($sformatf("bp_shifts_after_pop%0d", k), 32'(shift_cnt - base), 32'(n));
        end
        check("bp_chain_restored", 32'(chain_intact(200)), 32'd1);
        check("bp_irq", 32'(irq_o), 32'd1);
        wb_rd(A_STAT, 32'h2, "bp_status_end");

        // Abort, with ignored start and LEN writes mid-run
        preload(100, 1);
        base = shift_cnt;
        wb_wr(A_LEN, 32'd100, "len100");
        wb_wr(A_CTRL, 32'h1, "start100");
        wait_shifts(base, 20, "ab_mid");
        wb_wr(A_CTRL, 32'h1, "start_busy");
        wb_wr(A_LEN, 32'd5, "len_busy");
        wait_shifts(base, 48, "ab_pre");
        wb_wr(A_CTRL, 32'h3, "abort");
        repeat (5) @(negedge wb_clk_i);
        n = shift_cnt - base;
        check("ab_shift_range", 32'(n >= 33 && n <= 63), 32'd1);
        repeat (5) @(negedge wb_clk_i);
        check("ab_stopped", 32'(shift_cnt - base), 32'(n));
        check("ab_shift_en", 32'(cfg_shift_en_o), 32'd0);
        check("ab_irq", 32'(irq_o), 32'd0);
        wb_rd(A_STAT, 32'h0000_0100, "ab_status");
        wb_rd(A_LEN, 32'd100, "ab_len_kept");
        wb_rd(A_DATA, exp_word(1, 100, 0), "ab_word0");
        wb_rd(A_STAT, 32'h0, "ab_status_drained");

        // Reset mid-SHIFT with a word buffered and underflow set
        wb_rd(A_DATA, 32'h0, "rst_pop_empty");
        preload(100, 0);
        base = shift_cnt;
        wb_wr(A_LEN, 32'd100, "len100b");
        wb_wr(A_CTRL, 32'h1, "start100b");
        wait_shifts(base, 40, "rst_mid");
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        check("rst_shift_en_low", 32'(cfg_shift_en_o), 32'd0);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        check_reset_outputs("post_reset");
        wb_rd(A_STAT, 32'h0, "post_reset_status");
        wb_rd(A_LEN, 32'h0, "post_reset_len");
        wb_rd(A_DATA, 32'h0, "post_reset_data");
        repeat (3) @(negedge wb_clk_i);
        check("scoreboard_drained", 32'(sbq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
